// File: rtl/sram_arbiter_ctrl_if.sv
// Request/response bundle for the two SRAM requesters (port A and port B).
interface sram_arbiter_ctrl_if;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 8;

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  // Requester side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_ack, a_rdata, b_ack, b_rdata
  );

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_ack, a_rdata, b_ack, b_rdata
  );
endinterface

// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin arbiter and cycle sequencer for a 2M x 8 asynchronous SRAM.
// Strobes, address and data-drive enable are registered and decoded from the state
// being entered, so each state's pin values appear in the cycle that state occupies.
module sram_arbiter_ctrl #(
  parameter int unsigned RD_WAIT = 3,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_arbiter_ctrl_if.slave   bus,
  output logic                 busy,
  output logic [20:0]          SRAM_A,
  inout  wire  [7:0]           SRAM_DQ,
  output logic                 SRAM_nCE,
  output logic                 SRAM_nOE,
  output logic                 SRAM_nWE
);
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  // Wait-state counts must fit the 4-bit down-counter and be non-zero
  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("sram_arbiter_ctrl: RD_WAIT must be in 1..15");
  end
  if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
    $error("sram_arbiter_ctrl: WR_WAIT must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic          last_grant;   // 0 = A, 1 = B
  logic          gnt_port;     // 0 = A, 1 = B
  logic          gnt_we;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] wait_cnt;
  logic          dq_oe;
  logic          pick_b_c;

  // B wins when it is the only requester, or on a tie when A was served last
  assign pick_b_c = bus.b_req && (!bus.a_req || !last_grant);

  // Write data is on the pins only while nWE is low
  assign SRAM_DQ = dq_oe ? wdata_q : {DW{1'bz}};

  // Arbitration, access sequencing and registered pin/handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt_port    <= 1'b0;
      gnt_we      <= 1'b0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      dq_oe       <= 1'b0;
      busy        <= 1'b0;
      SRAM_A      <= '0;
      SRAM_nCE    <= 1'b1;
      SRAM_nOE    <= 1'b1;
      SRAM_nWE    <= 1'b1;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
    end else begin
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            gnt_port   <= pick_b_c;
            last_grant <= pick_b_c;
            gnt_we     <= pick_b_c ? bus.b_we    : bus.a_we;
            SRAM_A     <= pick_b_c ? bus.b_addr  : bus.a_addr;
            wdata_q    <= pick_b_c ? bus.b_wdata : bus.a_wdata;
            SRAM_nCE   <= 1'b0;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (gnt_we) begin
            wait_cnt <= CW'(WR_WAIT - 1);
            SRAM_nWE <= 1'b0;
            dq_oe    <= 1'b1;
            state    <= WR;
          end else begin
            wait_cnt <= CW'(RD_WAIT - 1);
            SRAM_nOE <= 1'b0;
            state    <= RD;
          end
        end
        RD: begin
          if (wait_cnt == '0) begin
            SRAM_nCE <= 1'b1;
            SRAM_nOE <= 1'b1;
            if (gnt_port) begin
              bus.b_ack   <= 1'b1;
              bus.b_rdata <= SRAM_DQ;
            end else begin
              bus.a_ack   <= 1'b1;
              bus.a_rdata <= SRAM_DQ;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        WR: begin
          if (wait_cnt == '0) begin
            SRAM_nWE <= 1'b1;
            dq_oe    <= 1'b0;
            state    <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        HOLD: begin
          SRAM_nCE <= 1'b1;
          if (gnt_port) bus.b_ack <= 1'b1;
          else          bus.a_ack <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          SRAM_nCE <= 1'b1;
          SRAM_nOE <= 1'b1;
          SRAM_nWE <= 1'b1;
          dq_oe    <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  logic unused_c;
  assign unused_c = ^{AW'(0)};
endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed and random checks of sram_arbiter_ctrl; two instances cover the
// default wait states (3/2) and the extreme setting (1/15).
module tb_sram_arbiter_ctrl;
  logic clk;
  logic reset;
  bit   mon_en = 1'b0;

  logic [1:0][1:0]       req_i, we_i;
  logic [1:0][1:0][20:0] addr_i;
  logic [1:0][1:0][7:0]  wdata_i;

  logic [1:0][1:0]       ack_o;
  logic [1:0][1:0][7:0]  rdata_o;
  logic [1:0]            nce_o, noe_o, nwe_o, oe_o, busy_o;
  logic [1:0][7:0]       dq_o;
  logic [1:0][20:0]      sram_a_o;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   shadow [2][256];
  logic [255:0] sh_vld [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int unsigned RW = (d == 0) ? 3 : 1;
    localparam int unsigned WW = (d == 0) ? 2 : 15;

    sram_arbiter_ctrl_if bus ();
    logic [20:0]  sram_a;
    wire  [7:0]   sram_dq;
    logic         nce, noe, nwe, busy;
    logic [7:0]   mem [256];
    logic [255:0] vld;
    logic [7:0]   rd_val;
    int           viol = 0;
    int           gap = 0;
    int           min_gap = 1000;
    bit           seen = 1'b0;

    assign bus.a_req   = req_i[d][0];
    assign bus.a_we    = we_i[d][0];
    assign bus.a_addr  = addr_i[d][0];
    assign bus.a_wdata = wdata_i[d][0];
    assign bus.b_req   = req_i[d][1];
    assign bus.b_we    = we_i[d][1];
    assign bus.b_addr  = addr_i[d][1];
    assign bus.b_wdata = wdata_i[d][1];

    sram_arbiter_ctrl #(.RD_WAIT(RW), .WR_WAIT(WW)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .busy     (busy),
      .SRAM_A   (sram_a),
      .SRAM_DQ  (sram_dq),
      .SRAM_nCE (nce),
      .SRAM_nOE (noe),
      .SRAM_nWE (nwe)
    );

    // SRAM model: 256 locations aliased on the low address byte; unwritten reads return addr^0x5A
    assign rd_val  = vld[sram_a[7:0]] ? mem[sram_a[7:0]] : (sram_a[7:0] ^ 8'h5A);
    assign sram_dq = (!nce && !noe) ? rd_val : 8'bz;

    always @(posedge clk) begin
      if (reset) vld <= '0;
      else if (!nce && !nwe) begin
        mem[sram_a[7:0]] <= sram_dq;
        vld[sram_a[7:0]] <= 1'b1;
      end
    end

    // Bus-protocol monitor: strobe overlap, drive/nWE agreement, deselect gap between accesses
    always @(negedge clk) begin
      if (mon_en) begin
        if (!noe && !nwe) viol++;
        if (u_dut.dq_oe == nwe) viol++;
        if (nce) gap++;
        else begin
          if (seen && gap > 0 && gap < min_gap) min_gap = gap;
          gap  = 0;
          seen = 1'b1;
        end
      end
    end

    assign ack_o[d]      = {bus.b_ack, bus.a_ack};
    assign rdata_o[d][0] = bus.a_rdata;
    assign rdata_o[d][1] = bus.b_rdata;
    assign nce_o[d]      = nce;
    assign noe_o[d]      = noe;
    assign nwe_o[d]      = nwe;
    assign oe_o[d]       = u_dut.dq_oe;
    assign busy_o[d]     = busy;
    assign dq_o[d]       = sram_dq;
    assign sram_a_o[d]   = sram_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_mem(input int d, input logic [20:0] addr);
    return sh_vld[d][addr[7:0]] ? shadow[d][addr[7:0]] : (addr[7:0] ^ 8'h5A);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_i = '0;
    @(negedge clk);
    reset = 1'b0;
    sh_vld[0] = '0;
    sh_vld[1] = '0;
  endtask

  // One access from an idle DUT; checks ack cycle, strobe/drive masks, address, data, rdata
  task automatic access(input int d, input int p, input bit we, input logic [20:0] addr,
                        input logic [7:0] wdata, input bit drop_early, input string tag);
    int rw, ww, exp_ack, ack_cyc;
    logic [31:0] m_nce, m_noe, m_nwe, m_oe, e_nce, e_noe, e_nwe;
    logic [7:0] got_rd, exp_rd;
    bit a_bad, d_bad;
    rw = (d == 0) ? 3 : 1;
    ww = (d == 0) ? 2 : 15;
    exp_ack = we ? ww + 3 : rw + 2;
    e_nce = '0; e_noe = '0; e_nwe = '0;
    for (int n = 1; n < exp_ack; n++) e_nce[n] = 1'b1;
    for (int n = 2; n <= (we ? ww : rw) + 1; n++) begin
      if (we) e_nwe[n] = 1'b1;
      else    e_noe[n] = 1'b1;
    end
    exp_rd = exp_mem(d, addr);
    m_nce = '0; m_noe = '0; m_nwe = '0; m_oe = '0;
    a_bad = 1'b0; d_bad = 1'b0; ack_cyc = 0; got_rd = '0;

    @(negedge clk);
    req_i[d][p]   = 1'b1;
    we_i[d][p]    = we;
    addr_i[d][p]  = addr;
    wdata_i[d][p] = wdata;
    @(posedge clk);
    for (int n = 1; n < 30 && ack_cyc == 0; n++) begin
      @(negedge clk);
      if (drop_early && n == 1) req_i[d][p] = 1'b0;
      m_nce[n] = !nce_o[d];
      m_noe[n] = !noe_o[d];
      m_nwe[n] = !nwe_o[d];
      m_oe[n]  = oe_o[d];
      if (!nce_o[d] && sram_a_o[d] !== addr) a_bad = 1'b1;
      if (!nwe_o[d] && dq_o[d] !== wdata) d_bad = 1'b1;
      if (ack_o[d][p]) begin
        ack_cyc = n;
        got_rd  = rdata_o[d][p];
        req_i[d][p] = 1'b0;
      end
    end
    req_i[d][p] = 1'b0;
    check({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
    check({tag, "_nce_mask"}, m_nce, e_nce);
    check({tag, "_noe_mask"}, m_noe, e_noe);
    check({tag, "_nwe_mask"}, m_nwe, e_nwe);
    check({tag, "_dq_drive_mask"}, m_oe, e_nwe);
    check({tag, "_addr_ok"}, 32'(a_bad), 32'd0);
    if (we) begin
      check({tag, "_wdata_ok"}, 32'(d_bad), 32'd0);
      shadow[d][addr[7:0]] = wdata;
      sh_vld[d][addr[7:0]] = 1'b1;
    end else begin
      check({tag, "_rdata"}, 32'(got_rd), 32'(exp_rd));
    end
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'(ack_o[d]), 32'd0);
    check({tag, "_busy_after"}, 32'(busy_o[d]), 32'd0);
  endtask

  logic [1:0]      pend;
  logic [1:0]      rwe;
  logic [1:0][20:0] raddr;
  logic [1:0][7:0]  rwd;
  int              n_ops = 0;

  // One cycle of random two-port traffic on the 1/15 instance with a shadow-memory scoreboard
  task automatic rnd_step(input bit allow_new);
    @(negedge clk);
    check("rnd_ack_pending", 32'(ack_o[1] & ~pend), 32'd0);
    for (int p = 0; p < 2; p++) begin
      if (ack_o[1][p] && pend[p]) begin
        if (rwe[p]) begin
          shadow[1][raddr[p][7:0]] = rwd[p];
          sh_vld[1][raddr[p][7:0]] = 1'b1;
        end else begin
          check("rnd_rdata", 32'(rdata_o[1][p]), 32'(exp_mem(1, raddr[p])));
        end
        pend[p] = 1'b0;
        req_i[1][p] = 1'b0;
        n_ops++;
      end else if (allow_new && !pend[p] && $urandom_range(0, 1) == 1) begin
        rwe[p]   = 1'($urandom_range(0, 1));
        raddr[p] = {13'($urandom), 8'($urandom_range(0, 15))};
        rwd[p]   = 8'($urandom);
        we_i[1][p]    = rwe[p];
        addr_i[1][p]  = raddr[p];
        wdata_i[1][p] = rwd[p];
        req_i[1][p]   = 1'b1;
        pend[p] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [3:0] seq;
    int k, overlap, last_ack;
    reset = 1'b1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    sh_vld[0] = '0; sh_vld[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_nce", 32'(nce_o), 32'h3);
    check("rst_noe", 32'(noe_o), 32'h3);
    check("rst_nwe", 32'(nwe_o), 32'h3);
    check("rst_dq_drive", 32'(oe_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_ack", 32'(ack_o), 32'h0);
    check("rst_rdata", 32'(rdata_o), 32'h0);
    check("rst_addr0", 32'(sram_a_o[0]), 32'h0);
    check("rst_addr1", 32'(sram_a_o[1]), 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Default wait states: read top address, write, readback, B write then A read, early drop
    access(0, 0, 1'b0, 21'h1FFFFF, 8'h00, 1'b0, "a_rd_top");
    check("a_rd_top_value", 32'(rdata_o[0][0]), 32'hA5);
    access(0, 0, 1'b1, 21'h000123, 8'h3C, 1'b0, "a_wr_123");
    access(0, 0, 1'b0, 21'h000123, 8'h00, 1'b0, "a_rd_123");
    access(0, 1, 1'b1, 21'h000045, 8'h77, 1'b0, "b_wr_45");
    access(0, 0, 1'b1, 21'h000050, 8'h66, 1'b0, "a_wr_50");
    access(0, 0, 1'b0, 21'h000050, 8'h00, 1'b0, "a_rd_50");
    access(0, 1, 1'b0, 21'h000045, 8'h00, 1'b1, "b_rd_drop");
    check("a_rdata_held", 32'(rdata_o[0][0]), 32'h66);

    // Both ports requesting continuously: A first after reset, then strict alternation
    do_reset();
    @(negedge clk);
    req_i[0] = 2'b11; we_i[0] = 2'b00;
    addr_i[0][0] = 21'h000010; addr_i[0][1] = 21'h000020;
    seq = '0; k = 0; overlap = 0; last_ack = 0;
    for (int n = 0; n < 60 && k < 4; n++) begin
      @(negedge clk);
      if (ack_o[0] == 2'b11) overlap++;
      if (ack_o[0][0] || ack_o[0][1]) begin
        seq[k] = ack_o[0][1];
        if (ack_o[0][0]) check("rr_a_rdata", 32'(rdata_o[0][0]), 32'h4A);
        else             check("rr_b_rdata", 32'(rdata_o[0][1]), 32'h7A);
        last_ack = n + 1;
        k++;
      end
    end
    req_i[0] = 2'b00;
    check("rr_count", 32'(k), 32'd4);
    check("rr_order", 32'(seq), 32'hA);
    check("rr_overlap", 32'(overlap), 32'd0);
    check("rr_last_ack_cycle", 32'(last_ack), 32'd23);
    repeat (3) @(negedge clk);

    // Reset in the second write-strobe cycle abandons the access cleanly
    @(negedge clk);
    req_i[0][0] = 1'b1; we_i[0][0] = 1'b1; addr_i[0][0] = 21'h000077; wdata_i[0][0] = 8'hE1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_wr_strobe", 32'(nwe_o[0]), 32'd0);
    reset = 1'b1;
    req_i[0][0] = 1'b0;
    @(negedge clk);
    check("rst_mid_nwe", 32'(nwe_o[0]), 32'd1);
    check("rst_mid_nce", 32'(nce_o[0]), 32'd1);
    check("rst_mid_dq_drive", 32'(oe_o[0]), 32'd0);
    check("rst_mid_ack", 32'(ack_o[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_o[0]), 32'd0);
    reset = 1'b0;
    sh_vld[0] = '0; sh_vld[1] = '0;
    access(0, 0, 1'b0, 21'h000123, 8'h00, 1'b0, "post_rst_rd");

    // Extreme wait states: 1-cycle read, 15-cycle write
    access(1, 0, 1'b0, 21'h000AAA, 8'h00, 1'b0, "w1_rd");
    access(1, 1, 1'b1, 21'h0000BB, 8'h5C, 1'b0, "w15_wr");
    access(1, 0, 1'b0, 21'h0000BB, 8'h00, 1'b0, "w15_rd");

    // Random contention on the extreme instance
    pend = '0;
    for (int c = 0; c < 8000; c++) rnd_step(1'b1);
    for (int c = 0; c < 100 && pend != '0; c++) rnd_step(1'b0);
    check("rnd_drained", 32'(pend), 32'd0);
    check("rnd_ops_done", 32'(n_ops > 300), 32'd1);

    check("strobe_overlap_or_drive_dut0", 32'(g_dut[0].viol), 32'd0);
    check("strobe_overlap_or_drive_dut1", 32'(g_dut[1].viol), 32'd0);
    check("turnaround_gap_dut0", 32'(g_dut[0].min_gap >= 2), 32'd1);
    check("turnaround_gap_dut1", 32'(g_dut[1].min_gap >= 2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
